// File: rtl/prod_acc_pkg.sv
// Shared types and default sizes for the product accumulator.
package prod_acc_pkg;

  localparam int ACC_W_DEF  = 16;
  localparam int PROD_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;
  localparam int CNT_MAX    = 15;
  localparam int BYTE_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: one register and an AND-NOT.
// The register follows its input every cycle, regardless of any enable.
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic evt_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign evt_o = sig_i & ~sig_q;

endmodule

// File: rtl/prod_accumulator.sv
// Accumulates strobed multiplier products into a running sum and streams a snapshot out byte-wise.
// `ACC_SATURATE_EN clamps the sum to all-ones on overflow instead of wrapping.
module prod_accumulator
  import prod_acc_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PROD_W = PROD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_valid_i,
  input  logic              clear_i,
  input  logic              read_i,
  output logic [BYTE_W-1:0] acc_byte_o,
  output logic              byte_sel_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              ovf_o
);

  logic valid_evt;
  logic read_evt;

  rise_edge_det u_valid_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (prod_valid_i),
    .evt_o (valid_evt)
  );

  rise_edge_det u_read_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (read_i),
    .evt_o (read_evt)
  );

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  snap_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q;
  logic              carry;
  logic [ACC_W:0]    sum_ext;
  rd_state_t         state_q;
  logic [BYTE_W-1:0] acc_byte_q;
  logic              byte_sel_q;
  logic              busy_q;

  always_comb begin
    sum_ext = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, prod_i};
    carry   = sum_ext[ACC_W];
`ifdef ACC_SATURATE_EN
    acc_d   = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_d   = sum_ext[ACC_W-1:0];
`endif
    count_d = (count_q == CNT_W'(CNT_MAX)) ? count_q : count_q + CNT_W'(1);
  end

  // Clear wins over a same-cycle accumulate; the product is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (ena) begin
      if (clear_i) begin
        acc_q   <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (valid_evt) begin
        acc_q   <= acc_d;
        count_q <= count_d;
        ovf_q   <= ovf_q | carry;
      end
    end
  end

  // Snapshot takes the pre-update sum so same-cycle accumulate/clear never leaks into the stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      acc_byte_q <= '0;
      byte_sel_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (ena && read_evt) begin
      case (state_q)
        IDLE: begin
          state_q    <= RD_LO;
          snap_q     <= acc_q;
          acc_byte_q <= acc_q[BYTE_W-1:0];
          byte_sel_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        RD_LO: begin
          state_q    <= RD_HI;
          acc_byte_q <= snap_q[2*BYTE_W-1:BYTE_W];
          byte_sel_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          acc_byte_q <= '0;
          byte_sel_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign acc_byte_o = acc_byte_q;
  assign byte_sel_o = byte_sel_q;
  assign busy_o     = busy_q;
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator; inputs change and outputs are sampled on the falling edge.
module tb_prod_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] prod_i;
  logic       prod_valid_i;
  logic       clear_i;
  logic       read_i;
  logic [7:0] acc_byte_o;
  logic       byte_sel_o;
  logic       busy_o;
  logic [3:0] count_o;
  logic       ovf_o;

  int checks = 0;
  int errors = 0;

  prod_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .prod_i       (prod_i),
    .prod_valid_i (prod_valid_i),
    .clear_i      (clear_i),
    .read_i       (read_i),
    .acc_byte_o   (acc_byte_o),
    .byte_sel_o   (byte_sel_o),
    .busy_o       (busy_o),
    .count_o      (count_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic pulse_prod(input logic [7:0] p, input int len);
    @(negedge clk);
    prod_i = p;
    prod_valid_i = 1'b1;
    repeat (len) @(negedge clk);
    prod_valid_i = 1'b0;
  endtask

  task automatic pulse_read();
    @(negedge clk);
    read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; prod_i = '0; prod_valid_i = 1'b0; clear_i = 1'b0; read_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (acc_byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", acc_byte_o); end
    checks++; if (byte_sel_o !== 1'b0)  begin errors++; $display("FAIL reset_sel got %b exp 0", byte_sel_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (count_o !== 4'd0)     begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if (ovf_o !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_o); end
  endtask

  task automatic test_basic();
    pulse_prod(8'd225, 3);
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", count_o); end
    pulse_prod(8'd100, 3);
    pulse_prod(8'd1, 3);
    checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL basic_count3 got %0d exp 3", count_o); end
    pulse_read();
    checks++; if (acc_byte_o !== 8'h46 || byte_sel_o !== 1'b0 || busy_o !== 1'b1)
      begin errors++; $display("FAIL basic_lo got %h/%b/%b exp 46/0/1", acc_byte_o, byte_sel_o, busy_o); end
    pulse_read();
    checks++; if (acc_byte_o !== 8'h01 || byte_sel_o !== 1'b1 || busy_o !== 1'b1)
      begin errors++; $display("FAIL basic_hi got %h/%b/%b exp 01/1/1", acc_byte_o, byte_sel_o, busy_o); end
    pulse_read();
    checks++; if (acc_byte_o !== 8'h00 || byte_sel_o !== 1'b0 || busy_o !== 1'b0)
      begin errors++; $display("FAIL basic_idle got %h/%b/%b exp 00/0/0", acc_byte_o, byte_sel_o, busy_o); end
  endtask

  task automatic test_count_sat();
    do_clear();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", count_o); end
    for (int i = 0; i < 17; i++) pulse_prod(8'd1, 1);
    checks++; if (count_o !== 4'd15) begin errors++; $display("FAIL sat_count got %0d exp 15", count_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL sat_ovf got %b exp 0", ovf_o); end
    pulse_read();
    checks++; if (acc_byte_o !== 8'h11) begin errors++; $display("FAIL sat_lo got %h exp 11", acc_byte_o); end
    pulse_read();
    checks++; if (acc_byte_o !== 8'h00) begin errors++; $display("FAIL sat_hi got %h exp 00", acc_byte_o); end
    pulse_read();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_lo, exp_hi;
`ifdef ACC_SATURATE_EN
    exp_lo = 8'hFF; exp_hi = 8'hFF;
`else
    exp_lo = 8'hA4; exp_hi = 8'h00;
`endif
    do_clear();
    for (int i = 0; i < 291; i++) pulse_prod(8'd225, 1);
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ovf_o); end
    pulse_prod(8'd225, 1);
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_o); end
    pulse_read();
    checks++; if (acc_byte_o !== exp_lo) begin errors++; $display("FAIL ovf_lo got %h exp %h", acc_byte_o, exp_lo); end
    pulse_read();
    checks++; if (acc_byte_o !== exp_hi) begin errors++; $display("FAIL ovf_hi got %h exp %h", acc_byte_o, exp_hi); end
    pulse_read();
  endtask

  task automatic test_clear_collision();
    do_clear();
    pulse_prod(8'd16, 1);
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL coll_pre got %0d exp 1", count_o); end
    @(negedge clk);
    prod_i = 8'd7; prod_valid_i = 1'b1; clear_i = 1'b1;
    @(negedge clk);
    prod_valid_i = 1'b0; clear_i = 1'b0;
    checks++; if (count_o !== 4'd0 || ovf_o !== 1'b0)
      begin errors++; $display("FAIL coll_state got %0d/%b exp 0/0", count_o, ovf_o); end
    pulse_read();
    checks++; if (acc_byte_o !== 8'h00) begin errors++; $display("FAIL coll_lo got %h exp 00", acc_byte_o); end
    pulse_read();
    checks++; if (acc_byte_o !== 8'h00) begin errors++; $display("FAIL coll_hi got %h exp 00", acc_byte_o); end
    pulse_read();
  endtask

  task automatic test_read_same_cycle();
    do_clear();
    pulse_prod(8'd10, 1);
    @(negedge clk);
    prod_i = 8'd50; prod_valid_i = 1'b1; read_i = 1'b1;
    @(negedge clk);
    prod_valid_i = 1'b0; read_i = 1'b0;
    checks++; if (acc_byte_o !== 8'h0A || busy_o !== 1'b1)
      begin errors++; $display("FAIL same_lo got %h/%b exp 0A/1", acc_byte_o, busy_o); end
    pulse_read();
    checks++; if (acc_byte_o !== 8'h00 || byte_sel_o !== 1'b1)
      begin errors++; $display("FAIL same_hi got %h/%b exp 00/1", acc_byte_o, byte_sel_o); end
    pulse_read();
    pulse_read();
    checks++; if (acc_byte_o !== 8'h3C) begin errors++; $display("FAIL same_next got %h exp 3C", acc_byte_o); end
    pulse_read();
    pulse_read();
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL same_count got %0d exp 2", count_o); end
  endtask

  task automatic test_enable_reset();
    @(negedge clk);
    ena = 1'b0;
    pulse_prod(8'd5, 2);
    pulse_prod(8'd5, 2);
    pulse_read();
    checks++; if (count_o !== 4'd2 || busy_o !== 1'b0)
      begin errors++; $display("FAIL dis_hold got %0d/%b exp 2/0", count_o, busy_o); end
    @(negedge clk);
    prod_valid_i = 1'b1;
    @(negedge clk);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    prod_valid_i = 1'b0;
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL ena_rise got %0d exp 2", count_o); end
    pulse_read();
    checks++; if (acc_byte_o !== 8'h3C || busy_o !== 1'b1)
      begin errors++; $display("FAIL ena_lo got %h/%b exp 3C/1", acc_byte_o, busy_o); end
    ena = 1'b0;
    pulse_read();
    checks++; if (acc_byte_o !== 8'h3C || byte_sel_o !== 1'b0)
      begin errors++; $display("FAIL dis_fsm got %h/%b exp 3C/0", acc_byte_o, byte_sel_o); end
    ena = 1'b1;
    pulse_read();
    checks++; if (byte_sel_o !== 1'b1 || acc_byte_o !== 8'h00)
      begin errors++; $display("FAIL ena_hi got %h/%b exp 00/1", acc_byte_o, byte_sel_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || byte_sel_o !== 1'b0 || acc_byte_o !== 8'h00 || count_o !== 4'd0 || ovf_o !== 1'b0)
      begin errors++; $display("FAIL mid_reset got %b/%b/%h/%0d/%b exp all 0", busy_o, byte_sel_o, acc_byte_o, count_o, ovf_o); end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_read();
    checks++; if (acc_byte_o !== 8'h00 || busy_o !== 1'b1)
      begin errors++; $display("FAIL post_reset got %h/%b exp 00/1", acc_byte_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_count_sat();
    test_overflow();
    test_clear_collision();
    test_read_same_cycle();
    test_enable_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
